// File: rtl/clk_activity_monitor_if.sv
// Control/result bundle for clk_activity_monitor.
// master = status-register / host side, slave = the monitor.
interface clk_activity_monitor_if #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 16
);
    logic                          start;
    logic                          continuous;
    logic [CHANNELS*CNT_WIDTH-1:0] exp_min;
    logic [CHANNELS*CNT_WIDTH-1:0] exp_max;
    logic                          busy;
    logic                          valid;
    logic [CHANNELS*CNT_WIDTH-1:0] count_out;
    logic [CHANNELS-1:0]           in_range;
    logic [CHANNELS-1:0]           overflow;

    modport master (
        output start, continuous, exp_min, exp_max,
        input  busy, valid, count_out, in_range, overflow
    );

    modport slave (
        input  start, continuous, exp_min, exp_max,
        output busy, valid, count_out, in_range, overflow
    );
endinterface

// File: rtl/clk_activity_monitor.sv
// Multi-channel toggle-rate monitor: counts synchronised rising
// edges per channel over a fixed gate window and latches results.
module clk_activity_monitor #(
    parameter int CHANNELS    = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] toggle_in,
    clk_activity_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GATE,
        LATCH
    } state_t;

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CHANNELS-1:0]    sync_w;
    logic [CHANNELS-1:0]    hist_q;
    logic [CHANNELS-1:0]    rise_w;

    state_t                 state_q;
    logic [TW-1:0]          timer_q;
    logic [CNT_WIDTH-1:0]   cnt_q [CHANNELS];
    logic [CHANNELS-1:0]    ovf_q;

    logic                          busy_q;
    logic                          valid_q;
    logic [CHANNELS*CNT_WIDTH-1:0] count_q;
    logic [CHANNELS-1:0]           inr_q;
    logic [CHANNELS-1:0]           ovfo_q;

    // Synchroniser output and rising-edge detect against history
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sync_w[i] = sync_q[i][SYNC_STAGES-1];
        end
        rise_w = sync_w & ~hist_q;
    end

    // Free-running synchronisers; history tracks sync every cycle,
    // so at gate open it already equals sync and no false edge appears
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], toggle_in[i]};
            end
            hist_q <= sync_w;
        end
    end

    // Measurement FSM with gate timer, counters and registered results
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
            inr_q   <= '0;
            ovfo_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start || bus.continuous) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        cnt_q[i] <= '0;
                    end
                    ovf_q   <= '0;
                    timer_q <= GATE_LAST;
                    state_q <= GATE;
                end
                GATE: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (rise_w[i]) begin
                            if (cnt_q[i] == CNT_MAX) begin
                                ovf_q[i] <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    if (timer_q == '0) begin
                        state_q <= LATCH;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                LATCH: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        count_q[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_q[i];
                        inr_q[i] <= !ovf_q[i]
                            && (cnt_q[i] >= bus.exp_min[i*CNT_WIDTH +: CNT_WIDTH])
                            && (cnt_q[i] <= bus.exp_max[i*CNT_WIDTH +: CNT_WIDTH]);
                    end
                    ovfo_q  <= ovf_q;
                    valid_q <= 1'b1;
                    if (bus.continuous) begin
                        state_q <= ARM;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.count_out = count_q;
    assign bus.in_range  = inr_q;
    assign bus.overflow  = ovfo_q;

endmodule
